pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register for the 5-stage CPU, replacing fixed-width per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control field and a data payload between stages with a valid/ready handshake, synchronous flush, and an optional 2-entry skid buffer. Control bits are forced to zero whenever the stage holds a bubble. A saturating counter records downstream back-pressure cycles for performance analysis.

---
 rtl/pipe_stage_reg.sv | 121 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush,
// optional 2-entry skid buffer and a saturating back-pressure counter.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_EMPTY | no valid entry; output is a bubble
// S_ONE   | main entry valid and presented on the outputs
// S_TWO   | main and skid entries valid; upstream held off (SKID=1)
module pipe_stage_reg #(
  parameter int DATA_W = 105,
  parameter int CTRL_W = 4,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t            state_q, state_d;
  logic              ready_q;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0] main_data_q, skid_data_q;
  logic [CNT_W-1:0]  stall_q;
  logic              accept, xfer;
  logic              load_main_in, load_main_skid, load_skid;

  assign valid_o     = (state_q != S_EMPTY);
  assign ready_o     = (SKID != 0) ? ready_q : (~valid_o | ready_i);
  assign ctrl_o      = valid_o ? main_ctrl_q : '0;
  assign data_o      = main_data_q;
  assign stall_cnt_o = stall_q;
  assign accept      = valid_i & ready_o & ~flush_i;
  assign xfer        = valid_o & ready_i;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush_i) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_d      = S_ONE;
            load_main_in = 1'b1;
          end
        end
        S_ONE: begin
          if (accept && xfer) begin
            load_main_in = 1'b1;
          end else if (xfer) begin
            state_d = S_EMPTY;
          end else if (accept && (SKID != 0)) begin
            // new entry queues behind the head, so it is always the younger one
            state_d   = S_TWO;
            load_skid = 1'b1;
          end
        end
        S_TWO: begin
          if (ready_i) begin
            state_d        = S_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_comb begin
    case (state_q)
      S_ONE:   occupancy_o = 2'd1;
      S_TWO:   occupancy_o = 2'd2;
      default: occupancy_o = 2'd0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_EMPTY;
      ready_q     <= 1'b1;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      stall_q     <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != S_TWO);
      if (load_main_in) begin
        main_ctrl_q <= ctrl_i;
        main_data_q <= data_i;
      end else if (load_main_skid) begin
        main_ctrl_q <= skid_ctrl_q;
        main_data_q <= skid_data_q;
      end
      if (load_skid) begin
        skid_ctrl_q <= ctrl_i;
        skid_data_q <= data_i;
      end
      if (valid_o && !ready_i && (stall_q != {CNT_W{1'b1}}))
        stall_q <= stall_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 and a SKID=0 instance share stimulus and
// are checked against queue-based models of the stage.
module tb_pipe_stage_reg;
  localparam int DW = 16;
  localparam int CW = 4;
  localparam int NW = 4;
  localparam int SAT = (1 << NW) - 1;

  typedef logic [CW+DW-1:0] ent_t;

  logic clk, rst_n, valid_i, flush_i, ready_i;
  logic [CW-1:0] ctrl_i;
  logic [DW-1:0] data_i;

  logic          rdy1, vld1, rdy0, vld0;
  logic [CW-1:0] ctrl1, ctrl0;
  logic [DW-1:0] data1, data0;
  logic [1:0]    occ1, occ0;
  logic [NW-1:0] cnt1, cnt0;

  ent_t q1[$];
  ent_t q0[$];
  int   mc1, mc0;
  int   n_cmp, n_err;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(NW)) u_skid (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid_i), .ready_o(rdy1), .ctrl_i(ctrl_i),
    .data_i(data_i), .flush_i(flush_i), .valid_o(vld1), .ready_i(ready_i),
    .ctrl_o(ctrl1), .data_o(data1), .occupancy_o(occ1), .stall_cnt_o(cnt1));

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(NW)) u_noskid (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid_i), .ready_o(rdy0), .ctrl_i(ctrl_i),
    .data_i(data_i), .flush_i(flush_i), .valid_o(vld0), .ready_i(ready_i),
    .ctrl_o(ctrl0), .data_o(data0), .occupancy_o(occ0), .stall_cnt_o(cnt0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input bit v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input bit f, input bit r);
    valid_i = v; ctrl_i = c; data_i = d; flush_i = f; ready_i = r;
    #1;
  endtask

  // Advance one clock and apply the same edge to both models.
  task automatic tick();
    bit rd1, rd0, acc1, acc0, out1, out0;
    @(posedge clk);
    if (!rst_n) begin
      q1.delete(); q0.delete(); mc1 = 0; mc0 = 0;
    end else begin
      rd1  = (q1.size() < 2);
      rd0  = (q0.size() == 0) || ready_i;
      acc1 = valid_i && rd1 && !flush_i;
      acc0 = valid_i && rd0 && !flush_i;
      out1 = (q1.size() > 0) && ready_i;
      out0 = (q0.size() > 0) && ready_i;
      if (q1.size() > 0 && !ready_i && mc1 < SAT) mc1++;
      if (q0.size() > 0 && !ready_i && mc0 < SAT) mc0++;
      if (flush_i) begin
        q1.delete(); q0.delete();
      end else begin
        if (out1) void'(q1.pop_front());
        if (acc1) q1.push_back({ctrl_i, data_i});
        if (out0) void'(q0.pop_front());
        if (acc0) q0.push_back({ctrl_i, data_i});
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, '0, '0, 0, 0);
    tick(); tick();
    n_cmp++; if (vld1 !== 1'b0 || vld0 !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b/%b exp=0/0", vld1, vld0); end
    n_cmp++; if (ctrl1 !== '0 || ctrl0 !== '0) begin n_err++; $display("FAIL reset_ctrl got=%h/%h exp=0/0", ctrl1, ctrl0); end
    n_cmp++; if (data1 !== '0 || data0 !== '0) begin n_err++; $display("FAIL reset_data got=%h/%h exp=0/0", data1, data0); end
    n_cmp++; if (occ1 !== 2'd0 || occ0 !== 2'd0) begin n_err++; $display("FAIL reset_occ got=%0d/%0d exp=0/0", occ1, occ0); end
    n_cmp++; if (cnt1 !== '0 || cnt0 !== '0) begin n_err++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", cnt1, cnt0); end
    n_cmp++; if (rdy1 !== 1'b1 || rdy0 !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b/%b exp=1/1", rdy1, rdy0); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_streaming();
    for (int k = 0; k < 9; k++) begin
      if (k < 8) drive(1, 4'hA, DW'(k), 0, 1);
      else       drive(0, 4'hA, '0, 0, 1);
      if (k == 0) begin
        n_cmp++; if (vld1 !== 1'b0 || vld0 !== 1'b0) begin n_err++; $display("FAIL stream_pre_valid got=%b/%b exp=0/0", vld1, vld0); end
      end else begin
        n_cmp++; if (vld1 !== 1'b1 || data1 !== DW'(k-1) || ctrl1 !== 4'hA)
          begin n_err++; $display("FAIL stream_skid k=%0d got v=%b d=%0d c=%h exp v=1 d=%0d c=a", k, vld1, data1, ctrl1, k-1); end
        n_cmp++; if (vld0 !== 1'b1 || data0 !== DW'(k-1) || ctrl0 !== 4'hA)
          begin n_err++; $display("FAIL stream_noskid k=%0d got v=%b d=%0d c=%h exp v=1 d=%0d c=a", k, vld0, data0, ctrl0, k-1); end
      end
      n_cmp++; if (cnt1 !== '0 || cnt0 !== '0 || occ0 > 2'd1)
        begin n_err++; $display("FAIL stream_cnt_occ k=%0d got cnt=%0d/%0d occ0=%0d exp 0/0 occ0<=1", k, cnt1, cnt0, occ0); end
      tick();
    end
    n_cmp++; if (vld1 !== 1'b0 || vld0 !== 1'b0) begin n_err++; $display("FAIL stream_drained got=%b/%b exp=0/0", vld1, vld0); end
  endtask

  task automatic test_backpressure();
    bit            v_tab[7] = '{1, 1, 1, 0, 0, 0, 0};
    bit            r_tab[7] = '{1, 1, 0, 0, 0, 1, 1};
    logic [DW-1:0] obs[$];
    for (int i = 0; i < 7; i++) begin
      drive(v_tab[i], 4'h3, DW'(i), 0, r_tab[i]);
      if (vld1 && ready_i) obs.push_back(data1);
      if (i == 3 || i == 4) begin
        n_cmp++; if (occ1 !== 2'd2 || rdy1 !== 1'b0)
          begin n_err++; $display("FAIL bp_two i=%0d got occ=%0d rdy=%b exp occ=2 rdy=0", i, occ1, rdy1); end
      end
      tick();
    end
    n_cmp++; if (obs.size() != 3) begin n_err++; $display("FAIL bp_count got=%0d exp=3", obs.size()); end
    for (int k = 0; k < 3 && k < obs.size(); k++) begin
      n_cmp++; if (obs[k] !== DW'(k)) begin n_err++; $display("FAIL bp_order k=%0d got=%0d exp=%0d", k, obs[k], k); end
    end
    n_cmp++; if (cnt1 !== NW'(3)) begin n_err++; $display("FAIL bp_stall got=%0d exp=3", cnt1); end
    n_cmp++; if (vld1 !== 1'b0) begin n_err++; $display("FAIL bp_empty got=%b exp=0", vld1); end
  endtask

  task automatic test_flush();
    drive(1, 4'h3, 16'd5, 0, 1); tick();
    drive(1, 4'h3, 16'd6, 0, 0); tick();
    n_cmp++; if (occ1 !== 2'd2) begin n_err++; $display("FAIL flush_setup got=%0d exp=2", occ1); end
    drive(1, 4'h3, 16'd9, 1, 0); tick();
    n_cmp++; if (vld1 !== 1'b0 || ctrl1 !== '0 || occ1 !== 2'd0 || rdy1 !== 1'b1)
      begin n_err++; $display("FAIL flush_state got v=%b c=%h occ=%0d rdy=%b exp 0 0 0 1", vld1, ctrl1, occ1, rdy1); end
    for (int i = 0; i < 4; i++) begin
      drive(0, '0, '0, 0, 1);
      n_cmp++; if (vld1 !== 1'b0 || data1 === 16'd9) begin n_err++; $display("FAIL flush_kill i=%0d got v=%b d=%0d exp v=0 d!=9", i, vld1, data1); end
      tick();
    end
    n_cmp++; if (cnt1 !== NW'(mc1)) begin n_err++; $display("FAIL flush_keeps_cnt got=%0d exp=%0d", cnt1, mc1); end
  endtask

  task automatic test_bubble();
    for (int i = 0; i < 3; i++) begin
      drive(0, 4'hF, 16'hFFFF, 0, 1);
      tick();
      n_cmp++; if (ctrl1 !== '0 || ctrl0 !== '0 || vld1 !== 1'b0)
        begin n_err++; $display("FAIL bubble i=%0d got c=%h/%h v=%b exp 0/0 0", i, ctrl1, ctrl0, vld1); end
    end
  endtask

  task automatic test_saturation();
    drive(1, 4'h2, 16'd7, 0, 0); tick();
    for (int i = 0; i < 20; i++) begin
      drive(0, '0, '0, 0, 0); tick();
      n_cmp++; if (cnt1 !== NW'(mc1) || vld1 !== 1'b1 || data1 !== 16'd7)
        begin n_err++; $display("FAIL sat_step i=%0d got cnt=%0d v=%b d=%0d exp cnt=%0d v=1 d=7", i, cnt1, vld1, data1, mc1); end
    end
    n_cmp++; if (cnt1 !== NW'(15) || cnt0 !== NW'(15)) begin n_err++; $display("FAIL sat_final got=%0d/%0d exp=15/15", cnt1, cnt0); end
    drive(0, '0, '0, 1, 0); tick();
    n_cmp++; if (cnt1 !== NW'(15) || vld1 !== 1'b0) begin n_err++; $display("FAIL sat_after_flush got cnt=%0d v=%b exp 15 0", cnt1, vld1); end
  endtask

  task automatic test_async_reset();
    drive(1, 4'h1, 16'd1, 0, 1); tick();
    drive(1, 4'h1, 16'd2, 0, 0); tick();
    n_cmp++; if (occ1 !== 2'd2) begin n_err++; $display("FAIL arst_setup got=%0d exp=2", occ1); end
    drive(0, '0, '0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    q1.delete(); q0.delete(); mc1 = 0; mc0 = 0;
    #1;
    n_cmp++; if (vld1 !== 1'b0 || ctrl1 !== '0 || data1 !== '0 || occ1 !== 2'd0 || cnt1 !== '0 || rdy1 !== 1'b1)
      begin n_err++; $display("FAIL arst_outputs got v=%b c=%h d=%h occ=%0d cnt=%0d rdy=%b exp 0 0 0 0 0 1", vld1, ctrl1, data1, occ1, cnt1, rdy1); end
    n_cmp++; if (vld0 !== 1'b0 || cnt0 !== '0) begin n_err++; $display("FAIL arst_noskid got v=%b cnt=%0d exp 0 0", vld0, cnt0); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    ent_t h;
    for (int i = 0; i < 400; i++) begin
      drive(bit'($urandom_range(0, 1)), CW'($urandom), DW'($urandom),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 9) < 7));
      n_cmp++; if (vld1 !== (q1.size() > 0) || occ1 !== 2'(q1.size()) || rdy1 !== (q1.size() < 2) || cnt1 !== NW'(mc1))
        begin n_err++; $display("FAIL rnd_skid_state i=%0d got v=%b occ=%0d rdy=%b cnt=%0d exp size=%0d cnt=%0d", i, vld1, occ1, rdy1, cnt1, q1.size(), mc1); end
      if (q1.size() > 0) begin
        h = q1[0];
        n_cmp++; if (ctrl1 !== h[CW+DW-1:DW] || data1 !== h[DW-1:0])
          begin n_err++; $display("FAIL rnd_skid_head i=%0d got c=%h d=%h exp c=%h d=%h", i, ctrl1, data1, h[CW+DW-1:DW], h[DW-1:0]); end
      end else begin
        n_cmp++; if (ctrl1 !== '0) begin n_err++; $display("FAIL rnd_skid_bubble i=%0d got c=%h exp 0", i, ctrl1); end
      end
      n_cmp++; if (vld0 !== (q0.size() > 0) || occ0 !== 2'(q0.size()) || rdy0 !== ((q0.size() == 0) || ready_i) || cnt0 !== NW'(mc0))
        begin n_err++; $display("FAIL rnd_noskid_state i=%0d got v=%b occ=%0d rdy=%b cnt=%0d exp size=%0d cnt=%0d", i, vld0, occ0, rdy0, cnt0, q0.size(), mc0); end
      if (q0.size() > 0) begin
        h = q0[0];
        n_cmp++; if (ctrl0 !== h[CW+DW-1:DW] || data0 !== h[DW-1:0])
          begin n_err++; $display("FAIL rnd_noskid_head i=%0d got c=%h d=%h exp c=%h d=%h", i, ctrl0, data0, h[CW+DW-1:DW], h[DW-1:0]); end
      end else begin
        n_cmp++; if (ctrl0 !== '0) begin n_err++; $display("FAIL rnd_noskid_bubble i=%0d got c=%h exp 0", i, ctrl0); end
      end
      tick();
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; mc1 = 0; mc0 = 0;
    rst_n = 1'b0;
    valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0; ctrl_i = '0; data_i = '0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_bubble();
    test_saturation();
    test_async_reset();
    test_streaming();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
